sram_write_arbiter: RTL

Shares the single write port of `contiguous_sram` between the delay engine (`delay_master`) and a built-in zero-fill sequencer, which clears a freshly allocated delay region before it is used. The read channel passes straight through. Delay writes always take priority. The block sits between `delay_master` and `contiguous_sram` inside `pipeline_seq`. Clear commands come from the same control path that issues `alloc_sram_delay`.

---
 rtl/sram_write_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sram_write_arbiter.sv
// Shares the contiguous_sram write port between delay_master writes and a zero-fill
// sequencer; delay writes have priority and the read channel passes straight through.
module sram_write_arbiter #(
  parameter int data_width    = 16,
  parameter int addr_width    = 14,
  parameter int sram_capacity = 8192
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_read,
  input  logic [addr_width-1:0] d_read_addr,
  output logic                  d_read_ready,
  output logic [data_width-1:0] d_data_out,
  output logic                  d_read_invalid,
  input  logic                  d_write,
  input  logic [addr_width-1:0] d_write_addr,
  input  logic [data_width-1:0] d_data_in,
  output logic                  d_write_ready,
  output logic                  d_write_invalid,
  input  logic                  clr_start,
  input  logic [addr_width-1:0] clr_base,
  input  logic [addr_width-1:0] clr_size,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  clr_error,
  output logic                  s_read,
  output logic [addr_width-1:0] s_read_addr,
  input  logic [data_width-1:0] s_data_out,
  input  logic                  s_read_ready,
  input  logic                  s_read_invalid,
  output logic                  s_write,
  output logic [addr_width-1:0] s_write_addr,
  output logic [data_width-1:0] s_data_in,
  input  logic                  s_write_ready,
  input  logic                  s_write_invalid
);

  typedef enum logic [1:0] {W_IDLE, W_DELAY, W_CLEAR} w_state_t;
  typedef enum logic [2:0] {C_IDLE, C_ISSUE, C_WAIT, C_DONE, C_ERR} c_state_t;

  localparam logic [addr_width:0] CAP = (addr_width+1)'(sram_capacity);

  w_state_t              w_state, w_next;
  c_state_t              c_state, c_next;
  logic                  pend_vld, pend_load, pend_clear;
  logic [addr_width-1:0] pend_addr;
  logic [data_width-1:0] pend_data;
  logic                  drop, drop_q;
  logic                  issue_en;
  logic [addr_width-1:0] issue_addr;
  logic [data_width-1:0] issue_data;
  logic                  clr_grant, clr_accept, clr_step;
  logic [addr_width-1:0] clr_ptr, clr_cnt;
  logic [addr_width:0]   clr_end;

  assign s_read         = d_read;
  assign s_read_addr    = d_read_addr;
  assign d_read_ready   = s_read_ready;
  assign d_data_out     = s_data_out;
  assign d_read_invalid = s_read_invalid;

  assign clr_end  = {1'b0, clr_base} + {1'b0, clr_size};
  assign clr_step = (c_state == C_WAIT) && (w_state == W_CLEAR) && s_write_ready;

  always_comb begin
    w_next     = w_state;
    c_next     = c_state;
    issue_en   = 1'b0;
    issue_addr = '0;
    issue_data = '0;
    pend_load  = 1'b0;
    pend_clear = 1'b0;
    drop       = 1'b0;
    clr_grant  = 1'b0;
    clr_accept = 1'b0;

    // write owner: pending entry, then fresh delay write, then clear write
    case (w_state)
      W_IDLE: begin
        if (pend_vld) begin
          issue_en   = 1'b1;
          issue_addr = pend_addr;
          issue_data = pend_data;
          w_next     = W_DELAY;
          pend_load  = d_write;
          pend_clear = !d_write;
        end else if (d_write) begin
          issue_en   = 1'b1;
          issue_addr = d_write_addr;
          issue_data = d_data_in;
          w_next     = W_DELAY;
        end else if (c_state == C_ISSUE) begin
          issue_en   = 1'b1;
          issue_addr = clr_ptr;
          w_next     = W_CLEAR;
          clr_grant  = 1'b1;
        end
      end
      default: begin
        if (s_write_ready || s_write_invalid) w_next = W_IDLE;
        if (d_write) begin
          if (pend_vld) drop = 1'b1;
          else          pend_load = 1'b1;
        end
      end
    endcase

    // zero-fill sequencer
    case (c_state)
      C_IDLE: begin
        if (clr_start) begin
          if (clr_size == '0 || clr_end > CAP) begin
            c_next = C_ERR;
          end else begin
            c_next     = C_ISSUE;
            clr_accept = 1'b1;
          end
        end
      end
      C_ISSUE: if (clr_grant) c_next = C_WAIT;
      C_WAIT: begin
        if (clr_step)
          c_next = (clr_cnt == addr_width'(1)) ? C_DONE : C_ISSUE;
        else if (w_state == W_CLEAR && s_write_invalid)
          c_next = C_ERR;
      end
      default: c_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state      <= W_IDLE;
      c_state      <= C_IDLE;
      pend_vld     <= 1'b0;
      drop_q       <= 1'b0;
      s_write      <= 1'b0;
      s_write_addr <= '0;
      s_data_in    <= '0;
    end else begin
      w_state  <= w_next;
      c_state  <= c_next;
      pend_vld <= pend_load | (pend_vld & ~pend_clear);
      drop_q   <= drop;
      s_write  <= issue_en;
      if (issue_en) begin
        s_write_addr <= issue_addr;
        s_data_in    <= issue_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pend_load) begin
      pend_addr <= d_write_addr;
      pend_data <= d_data_in;
    end
    if (clr_accept) begin
      clr_ptr <= clr_base;
      clr_cnt <= clr_size;
    end else if (clr_step) begin
      clr_ptr <= clr_ptr + addr_width'(1);
      clr_cnt <= clr_cnt - addr_width'(1);
    end
  end

  // clear-owned responses never reach the delay side
  assign d_write_ready   = reset & s_write_ready & (w_state == W_DELAY);
  assign d_write_invalid = reset & ((s_write_invalid & (w_state == W_DELAY)) | drop_q);
  assign clr_busy        = reset & ((c_state == C_ISSUE) || (c_state == C_WAIT));
  assign clr_done        = reset & (c_state == C_DONE);
  assign clr_error       = reset & (c_state == C_ERR);

endmodule
